valid_stream_collector: RTL and testbench
=========================================

VALID_STREAM_COLLECTOR -- requirements
Module: valid_stream_collector

Interface
REQ-001 Parameter: width, 256, data word width in bits.
REQ-002 Parameter: depth, 16, FIFO entries; power of two, >= 2.
REQ-003 Parameter: max_inflight, 31, largest in-flight count the counter must hold; >= depth.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst_n  input  1  reset, synchronous and active-high despite the name; state clears when rst_n = 1 at posedge clk.
REQ-006 Port: issue  input  1  upstream launches one word into the fixed-latency pipeline this cycle.
REQ-007 Port: in_valid  input  1  pipeline output word valid; no backpressure possible.
REQ-008 Port: in_data  input  width  pipeline output word.
REQ-009 Port: can_issue  output  1  upstream may assert issue this cycle.
REQ-010 Port: out_valid  output  1  FIFO head valid.
REQ-011 Port: out_ready  input  1  downstream accepts head when out_valid = 1.
REQ-012 Port: out_data  output  width  FIFO head word.
REQ-013 Port: level  output  $clog2(depth+1)  current FIFO occupancy.
REQ-014 Port: overflow  output  1  sticky: word dropped because FIFO full.
REQ-015 Port: protocol_err  output  1  sticky: in_valid with zero words in flight.

Function
REQ-016 Storage: circular buffer of depth words; wr_ptr and rd_ptr of $clog2(depth) bits, wrap from depth-1 to 0.
REQ-017 push = in_valid and (level < depth, or pop in same cycle); pop = out_valid and out_ready.
REQ-018 On push: mem[wr_ptr] <= in_data, wr_ptr increments.
REQ-019 On pop: rd_ptr increments.
REQ-020 level next = level + push - pop; push and pop together leave level unchanged, including at level = depth and level = 1.
REQ-021 out_valid = (level != 0); out_data = mem[rd_ptr]; first-word fall-through.
REQ-022 Latency: in_valid at edge N with level = 0 gives out_valid = 1 and out_data = that word after edge N.
REQ-023 out_data is don't-care when out_valid = 0; out_ready ignored when out_valid = 0.
REQ-024 inflight counter: next = inflight + issue - (in_valid and inflight != 0); issue and in_valid together leave it unchanged.
REQ-025 can_issue = (inflight + level) < depth, combinational from registered state; guarantees no overflow while upstream obeys it.
REQ-026 issue while can_issue = 0 is still counted; overflow may result.
REQ-027 in_valid while level = depth and no pop: word dropped, pointers and level unchanged, overflow <= 1.
REQ-028 in_valid while inflight = 0: protocol_err <= 1; word still pushed per REQ-017; inflight stays 0.
REQ-029 overflow and protocol_err clear only on reset.
REQ-030 inflight saturates at max_inflight; further unbalanced issue sets protocol_err.

Reset
REQ-031 With rst_n = 1 at an edge: wr_ptr, rd_ptr, level and inflight go to 0; overflow and protocol_err go to 0; out_valid goes to 0; can_issue goes to 1.
REQ-032 Memory contents are not reset.
REQ-033 Reset overrides simultaneous issue, in_valid and out_ready; FIFO words present are discarded.
REQ-034 The first push is accepted at the first edge with rst_n = 0.

Verification
REQ-035 Pass-through, depth=16, out_ready=1: issue 1 cycle; in_valid with data 0xA5 ten cycles later -> out_valid=1, out_data=0xA5 one edge later; level returns to 0; inflight returns to 0.
REQ-036 Credit limit, out_ready=0: issue 16 cycles back-to-back -> can_issue=0 after the 16th issue; deliver 16 words 1..16 -> level=16, no overflow; pop all -> words read out in order 1..16.
REQ-037 Full boundary: at level=16, in_valid and out_ready together with data 0x77 -> level stays 16, head advances, overflow=0; 0x77 appears as the 16th word out.
REQ-038 Overflow: at level=16, out_ready=0, in_valid with data 0x55 -> overflow=1, level=16, 0x55 never output; overflow stays 1 until reset.
REQ-039 Protocol error: in_valid with inflight=0 -> protocol_err=1, word pushed, inflight=0.
REQ-040 Reset mid-operation: level=5 and inflight=3, assert rst_n=1 for 1 cycle together with issue and in_valid -> all counters 0, out_valid=0, can_issue=1, flags 0; the next push behaves as in REQ-035.

Source files
------------

// File: rtl/valid_stream_collector.sv
// Collects words from a fixed-latency, no-backpressure pipeline into a FWFT FIFO.
// Issue credits are granted only while in-flight words plus stored words fit the FIFO.
module valid_stream_collector #(
  parameter int width        = 256,
  parameter int depth        = 16,
  parameter int max_inflight = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue,
  input  logic                         in_valid,
  input  logic [width-1:0]             in_data,
  output logic                         can_issue,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [width-1:0]             out_data,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic                         overflow,
  output logic                         protocol_err
);

  localparam int PTR_W = $clog2(depth);
  localparam int LVL_W = $clog2(depth + 1);
  localparam int IF_W  = $clog2(max_inflight + 1);
  localparam int SUM_W = ((IF_W > LVL_W) ? IF_W : LVL_W) + 1;

  logic [width-1:0] mem_q [depth];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [IF_W-1:0]  inflight_q, inflight_d;
  logic             overflow_q, overflow_d;
  logic             protocol_err_q, protocol_err_d;

  logic             full;
  logic             push;
  logic             pop;
  logic             inflight_dec;
  logic             inflight_sat;
  logic [SUM_W-1:0] occupancy;

  assign full         = (level_q == LVL_W'(depth));
  assign pop          = (level_q != '0) && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push         = in_valid && (!full || pop);
  assign inflight_dec = in_valid && (inflight_q != '0);
  assign inflight_sat = (inflight_q == IF_W'(max_inflight));
  assign occupancy    = SUM_W'(inflight_q) + SUM_W'(level_q);

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    inflight_d     = inflight_q;
    overflow_d     = overflow_q;
    protocol_err_d = protocol_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (issue && !inflight_dec) begin
      if (!inflight_sat) inflight_d = inflight_q + IF_W'(1);
    end else if (!issue && inflight_dec) begin
      inflight_d = inflight_q - IF_W'(1);
    end

    if (in_valid && !push) overflow_d = 1'b1;
    // Arrival with nothing outstanding, or an issue the saturated counter cannot record.
    if (in_valid && (inflight_q == '0)) protocol_err_d = 1'b1;
    if (issue && !inflight_dec && inflight_sat) protocol_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      inflight_q     <= '0;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      inflight_q     <= inflight_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && push) mem_q[wr_ptr_q] <= in_data;
  end

  assign can_issue    = (occupancy < SUM_W'(depth));
  assign out_valid    = (level_q != '0);
  assign out_data     = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_valid_stream_collector.sv
// Directed scenario bench for valid_stream_collector (depth 16, max_inflight 31).
module tb_valid_stream_collector;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         issue = 1'b0;
  logic         in_valid = 1'b0;
  logic [255:0] in_data = '0;
  logic         can_issue;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  logic [4:0]   level;
  logic         overflow;
  logic         protocol_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_d;

  valid_stream_collector #(.width(256), .depth(16), .max_inflight(31)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .in_valid(in_valid), .in_data(in_data),
    .can_issue(can_issue), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    rst_n = 1'b0;
  endtask

  // Issue n words then deliver count words starting at base, FIFO not draining.
  task automatic fill(input int n_issue, input int count, input int base);
    out_ready = 1'b0;
    issue = 1'b1;
    for (int i = 0; i < n_issue; i++) step();
    issue = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < count; i++) begin
      in_data = 256'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL reset_can_issue got %b exp 1", can_issue); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_protocol_err got %b exp 0", protocol_err); end
  endtask

  task automatic pass_through(input string tag);
    out_ready = 1'b1;
    issue = 1'b1;
    step();
    issue = 1'b0;
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL %s_can_issue got %b exp 1", tag, can_issue); end
    repeat (9) step();
    in_valid = 1'b1; in_data = 256'hA5;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_out_valid got %b exp 1", tag, out_valid); end
    n_checks++; if (out_data !== 256'hA5) begin n_fail++; $display("FAIL %s_out_data got %0h exp a5", tag, out_data); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL %s_level1 got %0d exp 1", tag, level); end
    step();
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL %s_level0 got %0d exp 0", tag, level); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL %s_protocol_err got %b exp 0", tag, protocol_err); end
    out_ready = 1'b0;
  endtask

  task automatic test_pass_through();
    do_reset();
    pass_through("pass");
  endtask

  task automatic test_credit_limit();
    out_ready = 1'b0;
    issue = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if (can_issue !== (i < 15)) begin n_fail++; $display("FAIL credit_can_issue[%0d] got %b exp %b", i, can_issue, (i < 15)); end
    end
    issue = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 256'(i);
      step();
      n_checks++;
      if (level !== 5'(i)) begin n_fail++; $display("FAIL credit_level[%0d] got %0d exp %0d", i, level, i); end
    end
    in_valid = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL credit_overflow got %b exp 0", overflow); end
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL credit_full_can_issue got %b exp 0", can_issue); end
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      exp_d = 256'(i);
      n_checks++;
      if (out_data !== exp_d || out_valid !== 1'b1) begin n_fail++; $display("FAIL credit_pop[%0d] got %0h valid %b exp %0h", i, out_data, out_valid, exp_d); end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL credit_drain_level got %0d exp 0", level); end
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL credit_drain_can_issue got %b exp 1", can_issue); end
  endtask

  task automatic test_full_boundary();
    do_reset();
    fill(17, 16, 'h10);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d exp 16", level); end
    n_checks++; if (out_data !== 256'h10) begin n_fail++; $display("FAIL full_head got %0h exp 10", out_data); end
    in_valid = 1'b1; in_data = 256'h77; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_pushpop_level got %0d exp 16", level); end
    n_checks++; if (out_data !== 256'h11) begin n_fail++; $display("FAIL full_head_adv got %0h exp 11", out_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow got %b exp 0", overflow); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL full_protocol_err got %b exp 0", protocol_err); end
    for (int j = 0; j < 16; j++) begin
      exp_d = (j == 15) ? 256'h77 : 256'('h11 + j);
      n_checks++;
      if (out_data !== exp_d) begin n_fail++; $display("FAIL full_pop[%0d] got %0h exp %0h", j, out_data, exp_d); end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL full_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_overflow();
    do_reset();
    fill(17, 16, 'h20);
    in_valid = 1'b1; in_data = 256'h55;
    step();
    in_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d exp 16", level); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL ovf_protocol_err got %b exp 0", protocol_err); end
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_d = 256'('h20 + j);
      n_checks++;
      if (out_data !== exp_d) begin n_fail++; $display("FAIL ovf_pop[%0d] got %0h exp %0h", j, out_data, exp_d); end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid got %b exp 0", out_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    do_reset();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear got %b exp 0", overflow); end
  endtask

  task automatic test_protocol_err();
    do_reset();
    in_valid = 1'b1; in_data = 256'h3C;
    step();
    in_valid = 1'b0;
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag got %b exp 1", protocol_err); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL perr_level got %0d exp 1", level); end
    n_checks++; if (out_data !== 256'h3C) begin n_fail++; $display("FAIL perr_data got %0h exp 3c", out_data); end
    issue = 1'b1;
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (can_issue !== 1'b1) begin n_fail++; $display("FAIL perr_inflight_credit[%0d] got %b exp 1", i, can_issue); end
      step();
    end
    issue = 1'b0;
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL perr_credit_exhaust got %b exp 0", can_issue); end
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got %b exp 1", protocol_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    issue = 1'b1;
    repeat (31) step();
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL sat_at_max got %b exp 0", protocol_err); end
    step();
    issue = 1'b0;
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL sat_overflow_err got %b exp 1", protocol_err); end
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL sat_can_issue got %b exp 0", can_issue); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(8, 5, 'h40);
    n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL mid_level got %0d exp 5", level); end
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL mid_can_issue got %b exp 1", can_issue); end
    rst_n = 1'b1; issue = 1'b1; in_valid = 1'b1; in_data = 256'h99; out_ready = 1'b1;
    step();
    rst_n = 1'b0; issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d exp 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL mid_rst_can_issue got %b exp 1", can_issue); end
    n_checks++; if (overflow !== 1'b0 || protocol_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags got %b%b exp 00", overflow, protocol_err); end
    pass_through("mid_pass");
    // Exactly 16 issues must exhaust credit if inflight truly cleared.
    test_credit_limit();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    do_reset();
    test_credit_limit();
    test_full_boundary();
    test_overflow();
    test_protocol_err();
    test_saturation();
    test_reset_mid();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
